// File: rtl/cursor_grid_ctrl.sv
// Cursor controller for the ship-placement grid: synchronised active-low buttons drive a
// registered (row, col) anchor and orientation, with hold-to-repeat and footprint clamping.
module cursor_grid_ctrl #(
    parameter int unsigned ROWS       = 5,
    parameter int unsigned COLS       = 5,
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned LEN_W      = 3,
    parameter int unsigned REP_DELAY  = 8,
    parameter int unsigned REP_PERIOD = 4,
    parameter int unsigned WRAP       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             move_up,
    input  logic             move_down,
    input  logic             move_left,
    input  logic             move_right,
    input  logic             rotate,
    input  logic             enable,
    input  logic [LEN_W-1:0] ship_len,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             horiz,
    output logic             moved,
    output logic             blocked
);

    localparam int unsigned CNT_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REP_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REP_PERIOD - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;
    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    // Bit order {rotate, up, down, left, right}; all active low.
    logic [4:0]       btn_s1;
    logic [4:0]       btn_s2;
    logic             rot_prev;
    logic             rot_fall;
    dir_t             active_dir;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    dir_t             dir_q;
    dir_t             dir_d;
    logic             step;

    logic [LEN_W-1:0] len_eff;
    logic [IDX_W-1:0] span_row;
    logic [IDX_W-1:0] span_col;
    logic [IDX_W-1:0] lim_row;
    logic [IDX_W-1:0] lim_col;
    logic [IDX_W-1:0] row_n;
    logic [IDX_W-1:0] col_n;
    logic             horiz_n;
    logic             refused;
    logic             changed;

    // rot_prev keeps tracking while disabled so edges seen then are dropped, not deferred.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1   <= '1;
            btn_s2   <= '1;
            rot_prev <= 1'b1;
        end else begin
            btn_s1   <= {rotate, move_up, move_down, move_left, move_right};
            btn_s2   <= btn_s1;
            rot_prev <= btn_s2[4];
        end
    end

    assign rot_fall = rot_prev & ~btn_s2[4];

    always_comb begin
        active_dir = DIR_NONE;
        if (!btn_s2[3])      active_dir = DIR_UP;
        else if (!btn_s2[2]) active_dir = DIR_DOWN;
        else if (!btn_s2[1]) active_dir = DIR_LEFT;
        else if (!btn_s2[0]) active_dir = DIR_RIGHT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    // A direction change drops to IDLE for one cycle; IDLE then issues the fresh step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        step    = 1'b0;
        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (active_dir != DIR_NONE) begin
                        step    = 1'b1;
                        state_d = ST_DELAY;
                        cnt_d   = '0;
                        dir_d   = active_dir;
                    end
                end
                ST_DELAY: begin
                    if (active_dir != dir_q) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == DELAY_LAST) begin
                        step    = 1'b1;
                        state_d = ST_REPEAT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (active_dir != dir_q) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == PERIOD_LAST) begin
                        step  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Rotate and clamp first, then apply the step against the new legal range.
    always_comb begin
        len_eff  = (ship_len == '0) ? LEN_W'(1) : ship_len;
        span_row = (32'(len_eff) > ROWS) ? '0 : IDX_W'(ROWS - 32'(len_eff));
        span_col = (32'(len_eff) > COLS) ? '0 : IDX_W'(COLS - 32'(len_eff));
        lim_row  = IDX_W'(ROWS - 1);
        lim_col  = IDX_W'(COLS - 1);
        horiz_n  = horiz;
        row_n    = row;
        col_n    = col;
        refused  = 1'b0;
        if (enable) begin
            horiz_n = horiz ^ rot_fall;
            if (horiz_n) lim_col = span_col;
            else         lim_row = span_row;
            if (row > lim_row) row_n = lim_row;
            if (col > lim_col) col_n = lim_col;
            if (step) begin
                case (active_dir)
                    DIR_UP: begin
                        if (row_n != '0)   row_n = row_n - IDX_W'(1);
                        else if (WRAP != 0) row_n = lim_row;
                        else               refused = 1'b1;
                    end
                    DIR_DOWN: begin
                        if (row_n < lim_row) row_n = row_n + IDX_W'(1);
                        else if (WRAP != 0)  row_n = '0;
                        else                 refused = 1'b1;
                    end
                    DIR_LEFT: begin
                        if (col_n != '0)   col_n = col_n - IDX_W'(1);
                        else if (WRAP != 0) col_n = lim_col;
                        else               refused = 1'b1;
                    end
                    DIR_RIGHT: begin
                        if (col_n < lim_col) col_n = col_n + IDX_W'(1);
                        else if (WRAP != 0)  col_n = '0;
                        else                 refused = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
        changed = (row_n != row) || (col_n != col) || (horiz_n != horiz);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row     <= '0;
            col     <= '0;
            horiz   <= 1'b1;
            moved   <= 1'b0;
            blocked <= 1'b0;
        end else begin
            row     <= row_n;
            col     <= col_n;
            horiz   <= horiz_n;
            moved   <= changed;
            blocked <= refused & ~changed;
        end
    end

endmodule

// File: tb/tb_cursor_grid_ctrl.sv
// Bench for cursor_grid_ctrl: a blocking (WRAP=0) and a wrapping (WRAP=1) instance share
// stimulus; both are scored every cycle against a hold-age reference model.
module tb_cursor_grid_ctrl;

    localparam int ROWS = 5;
    localparam int COLS = 5;
    localparam int RD   = 8;
    localparam int RP   = 4;

    // {rotate, up, down, left, right}, active low
    localparam logic [4:0] B_NONE  = 5'b11111;
    localparam logic [4:0] B_UP    = 5'b10111;
    localparam logic [4:0] B_DOWN  = 5'b11011;
    localparam logic [4:0] B_LEFT  = 5'b11101;
    localparam logic [4:0] B_RIGHT = 5'b11110;
    localparam logic [4:0] B_ROT   = 5'b01111;
    localparam logic [4:0] B_UD    = 5'b10011;
    localparam logic [4:0] B_DR    = 5'b11010;
    localparam logic [4:0] B_UR    = 5'b10110;

    logic       clk;
    logic       rst;
    logic       up, down, left, right, rot, en;
    logic [2:0] len;
    logic [2:0] row0, col0, row1, col1;
    logic       h0, mv0, bk0, h1, mv1, bk1;

    int n_tests = 0;
    int n_fail  = 0;

    cursor_grid_ctrl #(.WRAP(0)) dut0 (
        .clk(clk), .rst(rst), .move_up(up), .move_down(down), .move_left(left),
        .move_right(right), .rotate(rot), .enable(en), .ship_len(len),
        .row(row0), .col(col0), .horiz(h0), .moved(mv0), .blocked(bk0)
    );

    cursor_grid_ctrl #(.WRAP(1)) dut1 (
        .clk(clk), .rst(rst), .move_up(up), .move_down(down), .move_left(left),
        .move_right(right), .rotate(rot), .enable(en), .ship_len(len),
        .row(row1), .col(col1), .horiz(h1), .moved(mv1), .blocked(bk1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         m_row[2], m_col[2];
    bit         m_h[2], m_mv[2], m_bk[2];
    int         age;      // cycles since the first step of the current hold, -1 when idle
    int         cur_dir;
    logic [4:0] p1, p2, p3; // raw buttons seen 1, 2 and 3 edges ago

    function automatic void model_reset();
        for (int w = 0; w < 2; w++) begin
            m_row[w] = 0; m_col[w] = 0; m_h[w] = 1'b1; m_mv[w] = 1'b0; m_bk[w] = 1'b0;
        end
        age = -1; cur_dir = 0;
        p1 = '1; p2 = '1; p3 = '1;
    endfunction

    function automatic void model_edge();
        int d, l, r, c, tr, tc, maxr, maxc;
        bit h, stp, refused, rot_edge, mvd;
        if (!rst) begin
            model_reset();
        end else begin
            if (!en) begin
                for (int w = 0; w < 2; w++) begin m_mv[w] = 1'b0; m_bk[w] = 1'b0; end
            end else begin
                d = 0;
                if (!p2[3])      d = 1;
                else if (!p2[2]) d = 2;
                else if (!p2[1]) d = 3;
                else if (!p2[0]) d = 4;
                stp = 1'b0;
                if (age < 0) begin
                    if (d != 0) begin stp = 1'b1; age = 0; cur_dir = d; end
                end else if (d != cur_dir) begin
                    age = -1;
                end else begin
                    age++;
                    if (age == RD + 1 || (age > RD + 1 && (age - RD - 1) % RP == 0)) stp = 1'b1;
                end
                rot_edge = p3[4] && !p2[4];
                l = (len == 0) ? 1 : int'(len);
                for (int w = 0; w < 2; w++) begin
                    h    = m_h[w] ^ rot_edge;
                    maxr = h ? ROWS - 1 : (l > ROWS ? 0 : ROWS - l);
                    maxc = h ? (l > COLS ? 0 : COLS - l) : COLS - 1;
                    r = (m_row[w] > maxr) ? maxr : m_row[w];
                    c = (m_col[w] > maxc) ? maxc : m_col[w];
                    refused = 1'b0;
                    if (stp) begin
                        tr = r; tc = c;
                        case (d)
                            1: tr = r - 1;
                            2: tr = r + 1;
                            3: tc = c - 1;
                            4: tc = c + 1;
                            default: ;
                        endcase
                        if (tr < 0 || tr > maxr || tc < 0 || tc > maxc) begin
                            if (w == 1) begin
                                if (tr < 0) tr = maxr; else if (tr > maxr) tr = 0;
                                if (tc < 0) tc = maxc; else if (tc > maxc) tc = 0;
                                r = tr; c = tc;
                            end else begin
                                refused = 1'b1;
                            end
                        end else begin
                            r = tr; c = tc;
                        end
                    end
                    mvd = (r != m_row[w]) || (c != m_col[w]) || (h != m_h[w]);
                    m_mv[w]  = mvd;
                    m_bk[w]  = refused && !mvd;
                    m_row[w] = r; m_col[w] = c; m_h[w] = h;
                end
            end
            p3 = p2; p2 = p1; p1 = {rot, up, down, left, right};
        end
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        int ar[2], ac[2], ah[2], am[2], ab[2];
        ar[0] = int'(row0); ac[0] = int'(col0); ah[0] = int'(h0); am[0] = int'(mv0); ab[0] = int'(bk0);
        ar[1] = int'(row1); ac[1] = int'(col1); ah[1] = int'(h1); am[1] = int'(mv1); ab[1] = int'(bk1);
        for (int w = 0; w < 2; w++) begin
            n_tests++;
            if (ar[w] != m_row[w] || ac[w] != m_col[w] || ah[w] != int'(m_h[w]) ||
                am[w] != int'(m_mv[w]) || ab[w] != int'(m_bk[w])) begin
                n_fail++;
                $display("FAIL model_w%0d @%0t: got r%0d c%0d h%0d mv%0d bk%0d expected r%0d c%0d h%0d mv%0d bk%0d",
                         w, $time, ar[w], ac[w], ah[w], am[w], ab[w],
                         m_row[w], m_col[w], m_h[w], m_mv[w], m_bk[w]);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic set_btn(input logic [4:0] b);
        {rot, up, down, left, right} = b;
    endtask

    // One-cycle press; returns just after the edge where the step lands.
    task automatic press(input logic [4:0] b);
        set_btn(b);
        tick();
        set_btn(B_NONE);
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        set_btn(B_NONE);
        #1;
        model_reset();
        repeat (2) tick();
        rst = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0] btn;
        logic       en;
        logic [2:0] len;
        int         cycles;
        int         row;
        int         col;
        logic       h;
    } vec_t;

    vec_t vecs[18];

    longint unsigned mv_mask, bk_mask, exp_mv, exp_bk;
    int              hold;
    logic [4:0]      rb;

    initial begin
        rst = 1'b0; en = 1'b1; len = 3'd1;
        set_btn(B_NONE);

        vecs[0]  = '{B_DOWN,  1'b1, 3'd1, 1,  1, 0, 1'b1};
        vecs[1]  = '{B_DOWN,  1'b1, 3'd1, 1,  2, 0, 1'b1};
        vecs[2]  = '{B_RIGHT, 1'b1, 3'd1, 1,  2, 1, 1'b1};
        vecs[3]  = '{B_UP,    1'b1, 3'd1, 1,  1, 1, 1'b1};
        vecs[4]  = '{B_LEFT,  1'b1, 3'd1, 1,  1, 0, 1'b1};
        vecs[5]  = '{B_LEFT,  1'b1, 3'd1, 1,  1, 0, 1'b1};
        vecs[6]  = '{B_UD,    1'b1, 3'd1, 1,  0, 0, 1'b1};
        vecs[7]  = '{B_DR,    1'b1, 3'd1, 1,  1, 0, 1'b1};
        vecs[8]  = '{B_RIGHT, 1'b0, 3'd1, 1,  1, 0, 1'b1};
        vecs[9]  = '{B_RIGHT, 1'b1, 3'd4, 1,  1, 1, 1'b1};
        vecs[10] = '{B_RIGHT, 1'b1, 3'd4, 1,  1, 1, 1'b1};
        vecs[11] = '{B_NONE,  1'b1, 3'd5, 1,  1, 0, 1'b1};
        vecs[12] = '{B_ROT,   1'b1, 3'd5, 1,  0, 0, 1'b0};
        vecs[13] = '{B_DOWN,  1'b1, 3'd0, 1,  1, 0, 1'b0};
        vecs[14] = '{B_RIGHT, 1'b1, 3'd7, 1,  0, 1, 1'b0};
        vecs[15] = '{B_ROT,   1'b0, 3'd7, 1,  0, 1, 1'b0};
        vecs[16] = '{B_ROT,   1'b1, 3'd2, 1,  0, 1, 1'b1};
        vecs[17] = '{B_RIGHT, 1'b1, 3'd2, 12, 0, 3, 1'b1};

        // Reset values
        do_reset();
        check("rst_row", row0, 0);
        check("rst_col", col0, 0);
        check("rst_horiz", h0, 1);
        check("rst_moved", mv0, 0);
        check("rst_blocked", bk0, 0);

        // Table of presses from reset
        foreach (vecs[i]) begin
            len = vecs[i].len;
            en  = vecs[i].en;
            set_btn(vecs[i].btn);
            repeat (vecs[i].cycles) tick();
            set_btn(B_NONE);
            repeat (4) tick();
            check($sformatf("vec%0d_row", i), row0, vecs[i].row);
            check($sformatf("vec%0d_col", i), col0, vecs[i].col);
            check($sformatf("vec%0d_horiz", i), h0, vecs[i].h);
        end
        en = 1'b1;

        // One-cycle down press lands two edges after the input change
        len = 3'd3;
        do_reset();
        set_btn(B_DOWN);
        tick();
        set_btn(B_NONE);
        tick();
        check("lat_row_early", row0, 0);
        tick();
        check("lat_row", row0, 1);
        check("lat_moved", mv0, 1);
        tick();
        check("lat_moved_pulse", mv0, 0);

        // Vertical ship of length 3 stops at row 2
        do_reset();
        press(B_ROT);
        check("vert_horiz", h0, 0);
        check("vert_rot_moved", mv0, 1);
        repeat (2) tick();
        for (int k = 0; k < 4; k++) begin
            press(B_DOWN);
            check($sformatf("vert_row%0d", k), row0, (k == 0) ? 1 : 2);
            check($sformatf("vert_moved%0d", k), mv0, (k < 2) ? 1 : 0);
            check($sformatf("vert_blocked%0d", k), bk0, (k < 2) ? 0 : 1);
            repeat (2) tick();
        end

        // Hold right for 30 cycles: steps 2, 11, 15, 19 edges after the first, then refusals
        len = 3'd1;
        do_reset();
        mv_mask = 0; bk_mask = 0;
        set_btn(B_RIGHT);
        for (int j = 1; j <= 34; j++) begin
            if (j == 31) set_btn(B_NONE);
            tick();
            if (mv0) mv_mask |= (64'd1 << j);
            if (bk0) bk_mask |= (64'd1 << j);
        end
        exp_mv = (64'd1 << 3) | (64'd1 << 12) | (64'd1 << 16) | (64'd1 << 20);
        exp_bk = (64'd1 << 24) | (64'd1 << 28) | (64'd1 << 32);
        check("rep_moved_mask", int'(mv_mask[31:0]) ^ int'(mv_mask[63:32]), int'(exp_mv[31:0]) ^ int'(exp_mv[63:32]));
        check("rep_blocked_mask", int'(bk_mask[31:0]) ^ int'(bk_mask[63:32]), int'(exp_bk[31:0]) ^ int'(exp_bk[63:32]));
        check("rep_col", col0, 4);

        // Left from column 0: blocked without wrap, wraps to 4 with wrap
        do_reset();
        press(B_LEFT);
        check("wrap_col", col1, 4);
        check("wrap_moved", mv1, 1);
        check("wrap_blocked", bk1, 0);
        check("nowrap_col", col0, 0);
        check("nowrap_blocked", bk0, 1);
        check("nowrap_moved", mv0, 0);
        repeat (2) tick();

        // Rotate at row 4 with length 3 clamps to row 2 in the same cycle
        len = 3'd3;
        do_reset();
        repeat (4) begin press(B_DOWN); repeat (2) tick(); end
        check("rotclamp_pre_row", row0, 4);
        press(B_ROT);
        check("rotclamp_horiz", h0, 0);
        check("rotclamp_row", row0, 2);
        check("rotclamp_moved", mv0, 1);
        repeat (2) tick();

        // Up+right from (2,2) moves only the row; async reset mid-hold
        len = 3'd1;
        do_reset();
        repeat (2) begin press(B_DOWN); repeat (2) tick(); end
        repeat (2) begin press(B_RIGHT); repeat (2) tick(); end
        set_btn(B_UR);
        repeat (5) tick();
        check("prio_row", row0, 1);
        check("prio_col", col0, 2);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_row", row0, 0);
        check("async_col", col0, 0);
        check("async_horiz", h0, 1);
        tick();
        rst = 1'b1;
        repeat (3) tick();
        check("fresh_blocked", bk0, 1);
        check("fresh_wrap_row", row1, 4);
        set_btn(B_NONE);
        repeat (3) tick();

        // Randomised bursts scored against the model
        do_reset();
        for (int b = 0; b < 70; b++) begin
            case ($urandom_range(0, 6))
                0: rb = B_NONE;
                1: rb = B_UP;
                2: rb = B_DOWN;
                3: rb = B_LEFT;
                4: rb = B_RIGHT;
                default: rb = 5'b10000 | 5'($urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 4) == 0) rb[4] = 1'b0;
            if ($urandom_range(0, 3) == 0) len = 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 24);
            set_btn(rb);
            for (int j = 0; j < hold; j++) begin
                en = ($urandom_range(0, 11) != 0);
                if ($urandom_range(0, 15) == 0) rb[$urandom_range(0, 3)] ^= 1'b1;
                set_btn(rb);
                tick();
            end
        end
        en = 1'b1;
        set_btn(B_NONE);
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
